tv_sequencer: RTL
=================

# tv_sequencer

Synthesizable test-vector sequencer that sits directly upstream of a combinational DUT and checks its response. It holds a vector memory of packed {stimulus, expected} words and applies each stimulus to the DUT. After a programmable settle time it compares the DUT output against the expected value and counts mismatches. It replaces the simulation-only vector bench for on-board self-test of small logic blocks.

## Interface
- IN_W, 3: stimulus width (DUT input bits)
- OUT_W, 1: expected/response width (DUT output bits)
- DEPTH, 1024: vector memory entries; power of two
- SETTLE, 2: cycles between driving stimulus and sampling response; ≥1
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-low
- start  in  1  level; sampled in IDLE/DONE to begin a run
- num_vectors  in  $clog2(DEPTH)+1  vectors to run; sampled on start
- ld_we  in  1  vector load strobe; honoured only in IDLE/DONE
- ld_addr  in  $clog2(DEPTH)  load address
- ld_data  in  IN_W+OUT_W  packed vector, {stim[IN_W-1:0], exp[OUT_W-1:0]} (stim in MSBs)
- dut_in  out  IN_W  registered stimulus to DUT
- dut_out  in  OUT_W  DUT response
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- vectornum  out  $clog2(DEPTH)+1  vectors checked so far
- errors  out  32  mismatch count, saturating at 2^32-1
- err_pulse  out  1  one-cycle pulse in the CHECK cycle of a mismatch

## Operation
- States: IDLE, FETCH, APPLY, WAIT, CHECK, DONE.
- IDLE: busy=0, done=0. start=1 → latch num_vectors, clear errors/vectornum/idx.
  - num_vectors=0 → DONE.
  - Otherwise → FETCH.
- FETCH: memory read at idx issued (synchronous read, 1-cycle latency) → APPLY.
- APPLY: dut_in ← stim field, exp_q ← exp field; settle counter ← SETTLE-1 → WAIT.
- WAIT: counter decrements; at 0 → CHECK.
- CHECK: mismatch if dut_out != exp_q; mismatch → errors+1 (saturating) and err_pulse=1. vectornum+1, idx+1.
  - vectornum+1 == latched count → DONE.
  - Otherwise → FETCH.
- DONE: done=1, busy=0; dut_in holds last stimulus. start=1 → restart exactly as from IDLE.
- Loads: ld_we in FETCH/APPLY/WAIT/CHECK is dropped with no memory write. Load and start in the same IDLE cycle: write completes and the run reads the new data.
- num_vectors > DEPTH is clamped to DEPTH.
- Reset mid-run: next cycle IDLE. All counters cleared. Memory contents preserved.

## Timing
- Reset values: dut_in=0, busy=0, done=0, vectornum=0, errors=0, err_pulse=0.
- Per vector: FETCH 1 + APPLY 1 + WAIT SETTLE + CHECK 1 = SETTLE+3 cycles.
- Run latency, start sampled → done high: N·(SETTLE+3)+1 cycles.
- num_vectors=0: done high 1 cycle after start.
- dut_out is sampled on the clk edge ending CHECK. The DUT must settle within SETTLE+1 cycles of dut_in changing.
- errors and vectornum update on the same edge as the CHECK decision and are visible the following cycle.

## Configuration
- TV_ERR_LOG_EN defined: adds outputs first_err_idx ($clog2(DEPTH)), first_err_in (IN_W), first_err_out (OUT_W), first_err_valid (1).
  - Captured on the first mismatch of a run only; cleared on start and reset.
- Undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Package tv_pkg: state enum tv_state_t, stim/exp field slicing helpers, ERR_MAX constant.
- Sub-module tv_mem: single-clock simple dual-port RAM, DEPTH × (IN_W+OUT_W). Write port is the load port; read port is synchronous and addressed by idx.
- FSM, counters and compare live in tv_sequencer.

## Test plan
- DUT y=(~a&~b&~c)|(a&~b&~c)|(a&~b&c), SETTLE=2, 8 correct vectors 000_1..111_0 → done after 41 cycles, errors=0, vectornum=8.
- Same DUT, vectors 2 and 5 with inverted expected bit → errors=2, err_pulse exactly twice, vectornum=8.
  - With TV_ERR_LOG_EN: first_err_idx=2.
- num_vectors=0 with start → done next cycle, errors=0, dut_in=0.
- Reset low during WAIT of vector 3 → next cycle IDLE, outputs at reset values.
  - Restart with start → full 8-vector run passes; memory retained.
- ld_we pulsed during a run at address 0 with corrupted data → memory unchanged; a second run reports errors=0.
- Restart from DONE with start held 1 cycle → errors/vectornum cleared, identical results to the first run.

Source files
------------

// File: rtl/tv_pkg.sv
// Shared types and helpers for the test-vector sequencer.
// Optional feature macro: TV_ERR_LOG_EN (first-mismatch capture registers).
package tv_pkg;

  // Sequencer states; one vector takes FETCH, APPLY, WAIT (SETTLE cycles) and CHECK.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } tv_state_t;

  // Saturation value of the mismatch counter.
  localparam logic [31:0] ERR_MAX = 32'hFFFF_FFFF;

  // Widest packed vector the slicing helpers can handle.
  localparam int VEC_MAX_W = 64;

  // Stimulus field sits above the expected field in a packed vector.
  function automatic logic [VEC_MAX_W-1:0] stim_field(input logic [VEC_MAX_W-1:0] vec,
                                                      input int out_w);
    return vec >> out_w;
  endfunction

  // Expected field occupies the low out_w bits of a packed vector.
  function automatic logic [VEC_MAX_W-1:0] exp_field(input logic [VEC_MAX_W-1:0] vec,
                                                     input int out_w);
    return vec & ~({VEC_MAX_W{1'b1}} << out_w);
  endfunction

endpackage

// File: rtl/tv_mem.sv
// Vector memory: simple dual-port RAM, one clock, write port for loading,
// synchronous read port (one-cycle latency) for the sequencer.
module tv_mem #(
  parameter int W     = 4,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write on load strobe, registered read every cycle.
  // NOTE: the array and read register have no reset, so the RAM maps onto
  // block memory and its contents survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: applies stored stimuli to a combinational DUT, samples
// its response after a settle time and counts mismatches.
// Optional feature macro: TV_ERR_LOG_EN adds first-mismatch capture outputs.
module tv_sequencer
  import tv_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 1024,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_vectors,
  input  logic                       ld_we,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [IN_W+OUT_W-1:0]      ld_data,
  output logic [IN_W-1:0]            dut_in,
  input  logic [OUT_W-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     vectornum,
  output logic [31:0]                errors,
`ifdef TV_ERR_LOG_EN
  output logic [$clog2(DEPTH)-1:0]   first_err_idx,
  output logic [IN_W-1:0]            first_err_in,
  output logic [OUT_W-1:0]           first_err_out,
  output logic                       first_err_valid,
`endif
  output logic                       err_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = IN_W + OUT_W;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  tv_state_t         state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     idx_q;
  logic [SW-1:0]     settle_q;
  logic [OUT_W-1:0]  exp_q;
  logic [VW-1:0]     rd_data;
  logic [CW-1:0]     nv_clamped;
  logic              idle_like;
  logic              run_start;
  logic              mismatch;
  logic              last_vec;
  logic              mem_we;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign run_start  = idle_like && start;
  assign nv_clamped = (num_vectors > CW'(DEPTH)) ? CW'(DEPTH) : num_vectors;
  assign mismatch   = (state_q == ST_CHECK) && (dut_out != exp_q);
  assign last_vec   = (vectornum + CW'(1)) == count_q;
  assign mem_we     = ld_we && idle_like;

  assign busy      = !idle_like;
  assign done      = (state_q == ST_DONE);
  assign err_pulse = mismatch;

  tv_mem #(
    .W     (VW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  // State register with synchronous active-low reset.
  // NOTE: clocked state is always written with <= so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision for the vector walk.
  // NOTE: state_d gets its hold value first so no path through the case
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = (nv_clamped == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_APPLY;
      ST_APPLY: state_d = ST_WAIT;
      ST_WAIT:  state_d = (settle_q == '0) ? ST_CHECK : ST_WAIT;
      ST_CHECK: state_d = last_vec ? ST_DONE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: run setup, stimulus drive, settle timing, compare and counting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dut_in    <= '0;
      exp_q     <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      settle_q  <= '0;
      vectornum <= '0;
      errors    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_q   <= nv_clamped;
            idx_q     <= '0;
            vectornum <= '0;
            errors    <= '0;
          end
        end
        ST_APPLY: begin
          dut_in   <= IN_W'(stim_field(VEC_MAX_W'(rd_data), OUT_W));
          exp_q    <= OUT_W'(exp_field(VEC_MAX_W'(rd_data), OUT_W));
          settle_q <= SW'(SETTLE - 1);
        end
        ST_WAIT: begin
          if (settle_q != '0) begin
            settle_q <= settle_q - SW'(1);
          end
        end
        ST_CHECK: begin
          vectornum <= vectornum + CW'(1);
          idx_q     <= idx_q + AW'(1);
          if (mismatch && (errors != ERR_MAX)) begin
            errors <= errors + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TV_ERR_LOG_EN
  // Capture index, stimulus and response of the first mismatch of a run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      first_err_idx   <= '0;
      first_err_in    <= '0;
      first_err_out   <= '0;
      first_err_valid <= 1'b0;
    end else if (run_start) begin
      first_err_idx   <= '0;
      first_err_in    <= '0;
      first_err_out   <= '0;
      first_err_valid <= 1'b0;
    end else if (mismatch && !first_err_valid) begin
      first_err_idx   <= idx_q;
      first_err_in    <= dut_in;
      first_err_out   <= dut_out;
      first_err_valid <= 1'b1;
    end
  end
`endif

endmodule
